// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and limits for the two-port SRAM arbiter
package sram_arb_pkg;

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {GNT_INST, GNT_DATA} grant_t;

   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker, purely combinational
module rr_pick2
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   // req[0] = instruction, req[1] = data; grant 1 selects data
   always_comb begin
      grant = 1'b0;
      if (req == 2'b11)
         grant = ~last;
      else if (req[1])
         grant = 1'b1;
   end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - arbitrates instruction fetch and data access onto one SRAM port
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_done,
   output logic        inst_stall,
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_done,
   output logic        data_stall,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   state_t           state;
   grant_t           cur_grant;
   grant_t           last_grant;
   logic [CNT_W-1:0] cnt;
   logic             pick;
   logic             issue;
   logic             done_now;
   grant_t           pick_g;

   rr_pick2 u_pick (
      .req   ({data_req, inst_req}),
      .last  (last_grant == GNT_DATA),
      .grant (pick)
   );

   assign pick_g = pick ? GNT_DATA : GNT_INST;

   // Gating with rst keeps the SRAM port quiet during the reset cycle itself
   assign issue    = rst && (state == IDLE) && (inst_req || data_req);
   assign done_now = rst && (state == WAIT) && (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cur_grant  <= GNT_INST;
         last_grant <= GNT_INST;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  state      <= WAIT;
                  cnt        <= CNT_W'(WAIT_CYCLES);
                  cur_grant  <= pick_g;
                  last_grant <= pick_g;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sram_en    = issue;
   assign sram_addr  = issue ? (pick ? data_addr : inst_addr) : 32'h0;
   assign sram_wen   = (issue && pick) ? data_wen : 4'b0000;
   assign sram_wdata = (issue && pick) ? data_wdata : 32'h0;

   assign inst_done  = done_now && (cur_grant == GNT_INST);
   assign data_done  = done_now && (cur_grant == GNT_DATA);
   assign inst_stall = inst_req & ~inst_done;
   assign data_stall = data_req & ~data_done;
   assign inst_rdata = sram_rdata;
   assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - bench for sram_arbiter, instance 0 at WAIT_CYCLES=1, instance 1 at 3
module tb_sram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst[2];
   logic        inst_req[2];
   logic [31:0] inst_addr[2];
   logic        data_req[2];
   logic [3:0]  data_wen[2];
   logic [31:0] data_addr[2];
   logic [31:0] data_wdata[2];
   logic [31:0] sram_rdata[2];
   logic [31:0] inst_rdata[2];
   logic        inst_done[2];
   logic        inst_stall[2];
   logic [31:0] data_rdata[2];
   logic        data_done[2];
   logic        data_stall[2];
   logic        sram_en[2];
   logic [3:0]  sram_wen[2];
   logic [31:0] sram_addr[2];
   logic [31:0] sram_wdata[2];

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sram_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
         .clk        (clk),
         .rst        (rst[g]),
         .inst_req   (inst_req[g]),
         .inst_addr  (inst_addr[g]),
         .inst_rdata (inst_rdata[g]),
         .inst_done  (inst_done[g]),
         .inst_stall (inst_stall[g]),
         .data_req   (data_req[g]),
         .data_wen   (data_wen[g]),
         .data_addr  (data_addr[g]),
         .data_wdata (data_wdata[g]),
         .data_rdata (data_rdata[g]),
         .data_done  (data_done[g]),
         .data_stall (data_stall[g]),
         .sram_en    (sram_en[g]),
         .sram_wen   (sram_wen[g]),
         .sram_addr  (sram_addr[g]),
         .sram_wdata (sram_wdata[g]),
         .sram_rdata (sram_rdata[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; inst_req[i] = 1'b1; data_req[i] = 1'b1; data_wen[i] = 4'hF;
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            total++; if (sram_en[i] !== 1'b0) begin bad++; $display("FAIL reset_sram_en[%0d]: got %b want 0", i, sram_en[i]); end
            total++; if (sram_wen[i] !== 4'h0) begin bad++; $display("FAIL reset_sram_wen[%0d]: got %h want 0", i, sram_wen[i]); end
            total++; if (inst_done[i] !== 1'b0) begin bad++; $display("FAIL reset_inst_done[%0d]: got %b want 0", i, inst_done[i]); end
            total++; if (data_done[i] !== 1'b0) begin bad++; $display("FAIL reset_data_done[%0d]: got %b want 0", i, data_done[i]); end
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; inst_req[i] = 1'b0; data_req[i] = 1'b0; data_wen[i] = 4'h0;
      end
   endtask

   task automatic test_lone_fetch();
      logic [31:0] rd;
      inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC0_0000;
      @(negedge clk);
      total++; if (sram_en[0] !== 1'b1) begin bad++; $display("FAIL fetch_en: got %b want 1", sram_en[0]); end
      total++; if (sram_addr[0] !== 32'hBFC0_0000) begin bad++; $display("FAIL fetch_addr: got %h want bfc00000", sram_addr[0]); end
      total++; if (sram_wen[0] !== 4'h0) begin bad++; $display("FAIL fetch_wen: got %h want 0", sram_wen[0]); end
      total++; if (inst_done[0] !== 1'b0) begin bad++; $display("FAIL fetch_early_done: got %b want 0", inst_done[0]); end
      tick();
      rd = $urandom; sram_rdata[0] = rd;
      @(negedge clk);
      total++; if (inst_done[0] !== 1'b1) begin bad++; $display("FAIL fetch_done: got %b want 1", inst_done[0]); end
      total++; if (inst_rdata[0] !== rd) begin bad++; $display("FAIL fetch_rdata: got %h want %h", inst_rdata[0], rd); end
      total++; if (sram_en[0] !== 1'b0) begin bad++; $display("FAIL fetch_en_wait: got %b want 0", sram_en[0]); end
      total++; if (data_done[0] !== 1'b0) begin bad++; $display("FAIL fetch_data_done: got %b want 0", data_done[0]); end
      tick();
      inst_req[0] = 1'b0;
      @(negedge clk);
      total++; if (inst_done[0] !== 1'b0) begin bad++; $display("FAIL fetch_single_pulse: got %b want 0", inst_done[0]); end
      tick();
   endtask

   task automatic test_contest();
      logic [3:0] en_e = 4'b0101;
      logic [3:0] dd_e = 4'b0010;
      logic [3:0] id_e = 4'b1000;
      rst[0] = 1'b0; tick(); rst[0] = 1'b1;
      inst_req[0] = 1'b1; inst_addr[0] = 32'h0000_1000;
      data_req[0] = 1'b1; data_wen[0] = 4'b0011; data_addr[0] = 32'h0000_2000; data_wdata[0] = 32'hA5A5_1234;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++; if (sram_en[0] !== en_e[k]) begin bad++; $display("FAIL contest_en t%0d: got %b want %b", k, sram_en[0], en_e[k]); end
         total++; if (data_done[0] !== dd_e[k]) begin bad++; $display("FAIL contest_data_done t%0d: got %b want %b", k, data_done[0], dd_e[k]); end
         total++; if (inst_done[0] !== id_e[k]) begin bad++; $display("FAIL contest_inst_done t%0d: got %b want %b", k, inst_done[0], id_e[k]); end
         if (k == 0) begin
            total++; if (sram_addr[0] !== 32'h2000) begin bad++; $display("FAIL contest_data_addr: got %h want 2000", sram_addr[0]); end
            total++; if (sram_wen[0] !== 4'b0011) begin bad++; $display("FAIL contest_data_wen: got %h want 3", sram_wen[0]); end
            total++; if (sram_wdata[0] !== 32'hA5A5_1234) begin bad++; $display("FAIL contest_wdata: got %h want a5a51234", sram_wdata[0]); end
         end
         if (k == 2) begin
            total++; if (sram_addr[0] !== 32'h1000) begin bad++; $display("FAIL contest_inst_addr: got %h want 1000", sram_addr[0]); end
            total++; if (sram_wdata[0] !== 32'h0) begin bad++; $display("FAIL contest_inst_wdata: got %h want 0", sram_wdata[0]); end
         end
         tick();
         if (k == 1) data_req[0] = 1'b0;
         if (k == 3) inst_req[0] = 1'b0;
      end
      data_wen[0] = 4'h0;
   endtask

   task automatic test_alternate();
      int n = 0;
      logic exp_data;
      inst_req[0] = 1'b1; inst_addr[0] = 32'h0000_3000;
      data_req[0] = 1'b1; data_addr[0] = 32'h0000_4000; data_wen[0] = 4'hF;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         exp_data = ((k / 2) % 2) == 0;
         total++; if (sram_en[0] !== (k % 2 == 0)) begin bad++; $display("FAIL alt_en t%0d: got %b want %b", k, sram_en[0], k % 2 == 0); end
         if (k % 2 == 0) begin
            total++;
            if (sram_addr[0] !== (exp_data ? 32'h4000 : 32'h3000)) begin
               bad++; $display("FAIL alt_grant #%0d: got addr %h want %h", n, sram_addr[0], exp_data ? 32'h4000 : 32'h3000);
            end
            n++;
         end else begin
            total++; if (data_done[0] !== exp_data) begin bad++; $display("FAIL alt_data_done t%0d: got %b want %b", k, data_done[0], exp_data); end
            total++; if (inst_done[0] !== !exp_data) begin bad++; $display("FAIL alt_inst_done t%0d: got %b want %b", k, inst_done[0], !exp_data); end
         end
         tick();
      end
      inst_req[0] = 1'b0; data_req[0] = 1'b0; data_wen[0] = 4'h0;
   endtask

   task automatic test_wait3();
      logic [7:0] en_e = 8'b0001_0001;
      logic [7:0] dd_e = 8'b0000_1000;
      logic [7:0] id_e = 8'b1000_0000;
      inst_req[1] = 1'b1; inst_addr[1] = 32'h0000_7000;
      data_req[1] = 1'b1; data_wen[1] = 4'h0; data_addr[1] = 32'h0000_8000;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++; if (sram_en[1] !== en_e[k]) begin bad++; $display("FAIL w3_en t%0d: got %b want %b", k, sram_en[1], en_e[k]); end
         total++; if (data_done[1] !== dd_e[k]) begin bad++; $display("FAIL w3_data_done t%0d: got %b want %b", k, data_done[1], dd_e[k]); end
         total++; if (inst_done[1] !== id_e[k]) begin bad++; $display("FAIL w3_inst_done t%0d: got %b want %b", k, inst_done[1], id_e[k]); end
         total++; if (inst_stall[1] !== !id_e[k]) begin bad++; $display("FAIL w3_inst_stall t%0d: got %b want %b", k, inst_stall[1], !id_e[k]); end
         if (en_e[k]) begin
            total++;
            if (sram_addr[1] !== (k == 0 ? 32'h8000 : 32'h7000)) begin
               bad++; $display("FAIL w3_addr t%0d: got %h want %h", k, sram_addr[1], k == 0 ? 32'h8000 : 32'h7000);
            end
         end
         tick();
         if (k == 3) data_req[1] = 1'b0;
         if (k == 7) inst_req[1] = 1'b0;
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [6:0] en_e = 7'b000_1001;
      logic [6:0] dd_e = 7'b100_0000;
      data_req[1] = 1'b1; data_wen[1] = 4'h0; data_addr[1] = 32'h0000_5000;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         total++; if (sram_en[1] !== en_e[k]) begin bad++; $display("FAIL rmw_en t%0d: got %b want %b", k, sram_en[1], en_e[k]); end
         total++; if (data_done[1] !== dd_e[k]) begin bad++; $display("FAIL rmw_data_done t%0d: got %b want %b", k, data_done[1], dd_e[k]); end
         total++; if (inst_done[1] !== 1'b0) begin bad++; $display("FAIL rmw_inst_done t%0d: got %b want 0", k, inst_done[1]); end
         tick();
         if (k == 0) rst[1] = 1'b0;
         if (k == 2) rst[1] = 1'b1;
      end
      data_req[1] = 1'b0;
   endtask

   task automatic test_drop();
      logic [31:0] rd;
      data_req[0] = 1'b1; data_wen[0] = 4'b1000; data_addr[0] = 32'h0000_6000; data_wdata[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      total++; if (sram_en[0] !== 1'b1) begin bad++; $display("FAIL drop_issue: got %b want 1", sram_en[0]); end
      total++; if (sram_wen[0] !== 4'b1000) begin bad++; $display("FAIL drop_wen: got %h want 8", sram_wen[0]); end
      tick();
      data_req[0] = 1'b0; rd = $urandom; sram_rdata[0] = rd;
      @(negedge clk);
      total++; if (data_done[0] !== 1'b1) begin bad++; $display("FAIL drop_done: got %b want 1", data_done[0]); end
      total++; if (data_rdata[0] !== rd) begin bad++; $display("FAIL drop_rdata: got %h want %h", data_rdata[0], rd); end
      total++; if (sram_en[0] !== 1'b0) begin bad++; $display("FAIL drop_en_wait: got %b want 0", sram_en[0]); end
      tick();
      @(negedge clk);
      total++; if (sram_en[0] !== 1'b0) begin bad++; $display("FAIL drop_no_reissue: got %b want 0", sram_en[0]); end
      total++; if (data_done[0] !== 1'b0) begin bad++; $display("FAIL drop_single_pulse: got %b want 0", data_done[0]); end
      tick();
      data_wen[0] = 4'h0;
   endtask

   // Timestamp model: an access issued at cycle c completes at c+W and frees the port at c+W+1
   task automatic test_random(input int idx, input int ncyc);
      int          w = (idx == 0) ? 1 : 3;
      int          free_at = 0;
      int          done_at = -1;
      logic        g = 1'b0, last = 1'b0, pk;
      logic        prev_id = 1'b0, prev_dd = 1'b0;
      logic        e_en, e_id, e_dd;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_wen;
      for (int c = 0; c < ncyc; c++) begin
         rst[idx] = (c == 0) ? 1'b0 : ($urandom_range(63) != 0);
         if (inst_req[idx] && (prev_id || $urandom_range(31) == 0))
            inst_req[idx] = 1'b0;
         else if (!inst_req[idx] && $urandom_range(1) == 1) begin
            inst_req[idx] = 1'b1; inst_addr[idx] = $urandom;
         end
         if (data_req[idx] && (prev_dd || $urandom_range(31) == 0))
            data_req[idx] = 1'b0;
         else if (!data_req[idx] && $urandom_range(1) == 1) begin
            data_req[idx] = 1'b1; data_addr[idx] = $urandom; data_wdata[idx] = $urandom;
            data_wen[idx] = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15));
         end
         sram_rdata[idx] = $urandom;
         @(negedge clk);
         e_en = 1'b0; e_id = 1'b0; e_dd = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_wen = 4'h0;
         if (!rst[idx]) begin
            free_at = c + 1; done_at = -1; last = 1'b0;
         end else begin
            if (c == done_at) begin e_id = ~g; e_dd = g; end
            if (c >= free_at && (inst_req[idx] || data_req[idx])) begin
               pk = (inst_req[idx] && data_req[idx]) ? ~last : data_req[idx];
               g = pk; last = pk; e_en = 1'b1;
               done_at = c + w; free_at = c + w + 1;
               e_addr  = pk ? data_addr[idx] : inst_addr[idx];
               e_wen   = pk ? data_wen[idx] : 4'h0;
               e_wdata = pk ? data_wdata[idx] : 32'h0;
            end
         end
         total++; if (sram_en[idx] !== e_en) begin bad++; $display("FAIL rnd%0d_en c%0d: got %b want %b", idx, c, sram_en[idx], e_en); end
         total++; if (sram_wen[idx] !== e_wen) begin bad++; $display("FAIL rnd%0d_wen c%0d: got %h want %h", idx, c, sram_wen[idx], e_wen); end
         total++; if (inst_done[idx] !== e_id) begin bad++; $display("FAIL rnd%0d_inst_done c%0d: got %b want %b", idx, c, inst_done[idx], e_id); end
         total++; if (data_done[idx] !== e_dd) begin bad++; $display("FAIL rnd%0d_data_done c%0d: got %b want %b", idx, c, data_done[idx], e_dd); end
         total++; if (inst_stall[idx] !== (inst_req[idx] & ~e_id)) begin bad++; $display("FAIL rnd%0d_inst_stall c%0d: got %b want %b", idx, c, inst_stall[idx], inst_req[idx] & ~e_id); end
         total++; if (data_stall[idx] !== (data_req[idx] & ~e_dd)) begin bad++; $display("FAIL rnd%0d_data_stall c%0d: got %b want %b", idx, c, data_stall[idx], data_req[idx] & ~e_dd); end
         if (e_en) begin
            total++; if (sram_addr[idx] !== e_addr) begin bad++; $display("FAIL rnd%0d_addr c%0d: got %h want %h", idx, c, sram_addr[idx], e_addr); end
            total++; if (sram_wdata[idx] !== e_wdata) begin bad++; $display("FAIL rnd%0d_wdata c%0d: got %h want %h", idx, c, sram_wdata[idx], e_wdata); end
         end
         if (e_id) begin
            total++; if (inst_rdata[idx] !== sram_rdata[idx]) begin bad++; $display("FAIL rnd%0d_inst_rdata c%0d: got %h want %h", idx, c, inst_rdata[idx], sram_rdata[idx]); end
         end
         if (e_dd) begin
            total++; if (data_rdata[idx] !== sram_rdata[idx]) begin bad++; $display("FAIL rnd%0d_data_rdata c%0d: got %h want %h", idx, c, data_rdata[idx], sram_rdata[idx]); end
         end
         prev_id = e_id; prev_dd = e_dd;
         tick();
      end
      rst[idx] = 1'b1; inst_req[idx] = 1'b0; data_req[idx] = 1'b0; data_wen[idx] = 4'h0;
      repeat (w + 2) tick();
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; inst_req[i] = 1'b0; data_req[i] = 1'b0; data_wen[i] = 4'h0;
         inst_addr[i] = 32'h0; data_addr[i] = 32'h0; data_wdata[i] = 32'h0; sram_rdata[i] = 32'h0;
      end
      #1;
      test_reset();
      test_lone_fetch();
      test_contest();
      test_alternate();
      test_wait3();
      test_reset_mid_wait();
      test_drop();
      test_random(0, 600);
      test_random(1, 600);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
